// File: rtl/wave_pkg.sv
// Shared shape codes and scale constants for the waveform sample generator
// and its quarter-wave sine ROM.
package wave_pkg;

  typedef enum logic [1:0] {
    SHAPE_SINE   = 2'b00,
    SHAPE_SQUARE = 2'b01,
    SHAPE_TRI    = 2'b10,
    SHAPE_SAW    = 2'b11
  } shape_e;

  localparam logic [7:0]  MID_SCALE = 8'h80;
  localparam logic [7:0]  PHASE_MAX = 8'd255;
  localparam int unsigned LUT_LAST  = 64;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM: idx 0..64 -> round(128 + 127*sin(pi*idx/128)).
// Indices above 64 are never addressed and return mid-scale.
module sine_quarter_lut
  import wave_pkg::*;
(
  input  logic [6:0] idx,
  output logic [7:0] val
);

  always_comb begin
    val = MID_SCALE;
    case (idx)
      7'd0:    val = 8'd128;
      7'd1:    val = 8'd131;
      7'd2:    val = 8'd134;
      7'd3:    val = 8'd137;
      7'd4:    val = 8'd140;
      7'd5:    val = 8'd144;
      7'd6:    val = 8'd147;
      7'd7:    val = 8'd150;
      7'd8:    val = 8'd153;
      7'd9:    val = 8'd156;
      7'd10:   val = 8'd159;
      7'd11:   val = 8'd162;
      7'd12:   val = 8'd165;
      7'd13:   val = 8'd168;
      7'd14:   val = 8'd171;
      7'd15:   val = 8'd174;
      7'd16:   val = 8'd177;
      7'd17:   val = 8'd179;
      7'd18:   val = 8'd182;
      7'd19:   val = 8'd185;
      7'd20:   val = 8'd188;
      7'd21:   val = 8'd191;
      7'd22:   val = 8'd193;
      7'd23:   val = 8'd196;
      7'd24:   val = 8'd199;
      7'd25:   val = 8'd201;
      7'd26:   val = 8'd204;
      7'd27:   val = 8'd206;
      7'd28:   val = 8'd209;
      7'd29:   val = 8'd211;
      7'd30:   val = 8'd213;
      7'd31:   val = 8'd216;
      7'd32:   val = 8'd218;
      7'd33:   val = 8'd220;
      7'd34:   val = 8'd222;
      7'd35:   val = 8'd224;
      7'd36:   val = 8'd226;
      7'd37:   val = 8'd228;
      7'd38:   val = 8'd230;
      7'd39:   val = 8'd232;
      7'd40:   val = 8'd234;
      7'd41:   val = 8'd235;
      7'd42:   val = 8'd237;
      7'd43:   val = 8'd239;
      7'd44:   val = 8'd240;
      7'd45:   val = 8'd241;
      7'd46:   val = 8'd243;
      7'd47:   val = 8'd244;
      7'd48:   val = 8'd245;
      7'd49:   val = 8'd246;
      7'd50:   val = 8'd248;
      7'd51:   val = 8'd249;
      7'd52:   val = 8'd250;
      7'd53:   val = 8'd250;
      7'd54:   val = 8'd251;
      7'd55:   val = 8'd252;
      7'd56:   val = 8'd253;
      7'd57:   val = 8'd253;
      7'd58:   val = 8'd254;
      7'd59:   val = 8'd254;
      7'd60:   val = 8'd254;
      7'd61:   val = 8'd255;
      7'd62:   val = 8'd255;
      7'd63:   val = 8'd255;
      7'd64:   val = 8'd255;
      default: val = MID_SCALE;
    endcase
  end

endmodule

// File: rtl/wave_sample_gen.sv
// Waveform sample generator: one attenuated sample per falling edge of dbClock.
// Optional macro WAVE_PHASE_STEP_EN adds a Step input setting the phase increment.
module wave_sample_gen
  import wave_pkg::*;
#(
  parameter int unsigned PHASE_W = 8,
  parameter logic [7:0]  MID     = MID_SCALE
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       dbClock,
`ifdef WAVE_PHASE_STEP_EN
  input  logic [3:0] Step,
`endif
  input  logic [1:0] Shape,
  input  logic [1:0] Amp,
  output logic [7:0] DB,
  output logic       Valid,
  output logic       Wrap
);

  generate
    if (PHASE_W != 8) begin : g_bad_phase_w
      $error("wave_sample_gen: the sine ROM only supports PHASE_W = 8");
    end
  endgenerate

  logic              db_q, db_d;
  logic [7:0]        phase_q, phase_d;
  shape_e            shape_q, shape_d;
  logic [7:0]        dbus_q, dbus_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  logic              fall;
  logic [3:0]        step;
  logic [8:0]        phase_sum;
  logic [6:0]        lut_idx;
  logic [7:0]        lut_val;
  logic [7:0]        raw;
  logic signed [8:0] centred;
  logic signed [8:0] scaled;
  logic [7:0]        sample;

`ifdef WAVE_PHASE_STEP_EN
  assign step = Step;
`else
  assign step = 4'd1;
`endif

  assign fall      = db_q & ~dbClock;
  assign phase_sum = {1'b0, phase_q} + {5'd0, step};

  // Second quarter reads the table backwards so only 0..90 degrees is stored.
  always_comb begin
    lut_idx = {1'b0, phase_q[5:0]};
    if (phase_q[6]) begin
      lut_idx = 7'd64 - {1'b0, phase_q[5:0]};
    end
  end

  sine_quarter_lut u_sine_lut (
    .idx (lut_idx),
    .val (lut_val)
  );

  always_comb begin
    raw = phase_q;
    case (shape_q)
      SHAPE_SINE:   raw = phase_q[7] ? (8'd0 - lut_val) : lut_val;
      SHAPE_SQUARE: raw = phase_q[7] ? 8'h00 : 8'hFF;
      SHAPE_TRI:    raw = phase_q[7] ? ~{phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
      SHAPE_SAW:    raw = phase_q;
      default:      raw = phase_q;
    endcase
  end

  // Attenuate about mid-scale; |scaled| <= 128 so the 8-bit result never wraps.
  assign centred = $signed({1'b0, raw}) - $signed({1'b0, MID});
  assign scaled  = centred >>> Amp;
  assign sample  = 8'(scaled) + MID;

  always_comb begin
    db_d    = dbClock;
    phase_d = phase_q;
    shape_d = shape_q;
    dbus_d  = dbus_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (fall) begin
      dbus_d  = sample;
      phase_d = phase_sum[7:0];
      valid_d = 1'b1;
      wrap_d  = phase_sum[8];
      // The wrapping sample still uses the old shape; the new one starts at the next period.
      if (phase_sum[8]) begin
        shape_d = shape_e'(Shape);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      db_q    <= 1'b1;
      phase_q <= 8'd0;
      shape_q <= SHAPE_SINE;
      dbus_q  <= MID;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      db_q    <= db_d;
      phase_q <= phase_d;
      shape_q <= shape_d;
      dbus_q  <= dbus_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign DB    = dbus_q;
  assign Valid = valid_q;
  assign Wrap  = wrap_q;

endmodule

// File: tb/tb_wave_sample_gen.sv
// Testbench for wave_sample_gen: scoreboard of expected samples checked on every Valid.
module tb_wave_sample_gen;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       dbClock = 1'b1;
  logic [1:0] Shape = 2'b00;
  logic [1:0] Amp = 2'b00;
`ifdef WAVE_PHASE_STEP_EN
  logic [3:0] Step = 4'd1;
`endif
  logic [7:0] DB;
  logic       Valid;
  logic       Wrap;

  typedef struct packed {
    logic [7:0] db;
    logic       wrap;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   m_phase = 0;
  int   m_shape = 0;
  int   m_step = 1;
  int   m_prev_db = 128;
  int   m_cur_db = 128;

  localparam real PI = 3.14159265358979;

  always #5 Clk = ~Clk;

  wave_sample_gen dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .dbClock (dbClock),
`ifdef WAVE_PHASE_STEP_EN
    .Step    (Step),
`endif
    .Shape   (Shape),
    .Amp     (Amp),
    .DB      (DB),
    .Valid   (Valid),
    .Wrap    (Wrap)
  );

  function automatic int raw_of(input int shp, input int p);
    real s;
    case (shp)
      0: begin
        s = 128.0 + 127.0 * $sin(2.0 * PI * p / 256.0);
        return $rtoi(s + 0.5);
      end
      1: return (p < 128) ? 255 : 0;
      2: return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: return p;
    endcase
  endfunction

  function automatic int atten_of(input int raw, input int amp);
    int c;
    c = raw - 128;
    return (c >>> amp) + 128;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_mis++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    int   nxt;
    e.db      = 8'(atten_of(raw_of(m_shape, m_phase), int'(Amp)));
    nxt       = m_phase + m_step;
    e.wrap    = (nxt > 255);
    if (nxt > 255) m_shape = int'(Shape);
    m_phase   = nxt % 256;
    m_prev_db = m_cur_db;
    m_cur_db  = int'(e.db);
    sb_q.push_back(e);
  endtask

  // One dbClock low pulse of one cycle; entered and left at posedge+1.
  task automatic applyStimulus();
    pushExpected();
    dbClock = 1'b0;
    @(posedge Clk); #1;
    dbClock = 1'b1;
    @(negedge Clk); #1;
    checkOutput("sb_drain", sb_q.size(), 0);
    @(posedge Clk); #1;
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_shape   = 0;
    m_cur_db  = 128;
    m_prev_db = 128;
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Rst) begin
      if (Valid) begin
        checkOutput("valid_expected", Valid, sb_q.size() != 0);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checkOutput("db", DB, e.db);
          checkOutput("wrap", Wrap, e.wrap);
        end
      end else begin
        checkOutput("wrap_idle", Wrap, 0);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    int exp_db;
    $display("[TB] start");
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("rst_db", DB, 128);
    checkOutput("rst_valid", Valid, 0);
    checkOutput("rst_wrap", Wrap, 0);
    Rst = 1'b1;
    @(posedge Clk); #1;
    checkOutput("idle_db", DB, 128);

    // Period 1: sine from reset; request sawtooth mid-period
    for (int i = 0; i < 256; i++) begin
      if (i == 100) Shape = 2'b11;
      applyStimulus();
      if (i == 0)   checkOutput("sine_p0", DB, 128);
      if (i == 64)  checkOutput("sine_p64", DB, 255);
      if (i == 128) checkOutput("sine_p128", DB, 128);
      if (i == 192) checkOutput("sine_p192", DB, 1);
    end

    // Period 2: sawtooth; request square at phase 100
    for (int i = 0; i < 256; i++) begin
      if (i == 100) Shape = 2'b01;
      applyStimulus();
      if (i == 0)   checkOutput("saw_p0", DB, 0);
      if (i == 255) checkOutput("saw_p255", DB, 255);
    end

    // Period 3: square; request triangle at phase 100
    for (int i = 0; i < 256; i++) begin
      if (i == 100) Shape = 2'b10;
      applyStimulus();
      if (i == 0)   checkOutput("sq_p0", DB, 255);
      if (i == 127) checkOutput("sq_p127", DB, 255);
      if (i == 128) checkOutput("sq_p128", DB, 0);
    end

    // Period 4: triangle at Amp=1
    Amp = 2'b01;
    for (int i = 0; i < 256; i++) begin
      applyStimulus();
      if (i == 127) checkOutput("tri_a1_p127", DB, 191);
      if (i == 255) checkOutput("tri_a1_p255", DB, 64);
    end
    Amp = 2'b11;
    applyStimulus();
    checkOutput("tri_a3_p0", DB, 112);

    // dbClock held low for 10 cycles: exactly one update, one cycle after the fall
    pushExpected();
    dbClock = 1'b0;
    @(negedge Clk); #1;
    checkOutput("hold_db_before_edge", DB, m_prev_db);
    checkOutput("hold_valid_before_edge", Valid, 0);
    repeat (10) @(posedge Clk);
    #1;
    dbClock = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("hold_drain", sb_q.size(), 0);
    checkOutput("hold_db_after", DB, m_cur_db);

    // Reset mid-period while Valid is high
    Amp    = 2'b00;
    Shape  = 2'b01;
    exp_db = atten_of(raw_of(m_shape, m_phase), int'(Amp));
    dbClock = 1'b0;
    @(posedge Clk); #1;
    checkOutput("pre_rst_valid", Valid, 1);
    checkOutput("pre_rst_db", DB, exp_db);
    Rst = 1'b0;
    dbClock = 1'b1;
    #1;
    checkOutput("rst_mid_db", DB, 128);
    checkOutput("rst_mid_valid", Valid, 0);
    model_reset();
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    applyStimulus();
    checkOutput("post_rst_sine_p0", DB, 128);

`ifdef WAVE_PHASE_STEP_EN
    Rst = 1'b0;
    #1;
    model_reset();
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Shape  = 2'b11;
    Step   = 4'd4;
    m_step = 4;
    for (int i = 0; i < 64; i++) applyStimulus();
    for (int i = 0; i < 64; i++) begin
      applyStimulus();
      if (i == 0)  checkOutput("step4_saw_first", DB, 0);
      if (i == 63) checkOutput("step4_saw_last", DB, 252);
    end
    applyStimulus();
    Step   = 4'd0;
    m_step = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("step0_const", DB, 4);
    end
`endif

    repeat (4) @(posedge Clk);
    #1;
    checkOutput("final_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
